// File: rtl/riscv_chk_pkg.sv
// Shared types for the RISC-V result checker: FSM states, failure codes and
// the expected-result table entry layout.
package riscv_chk_pkg;

    localparam int CHK_DWIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } chk_state_e;

    typedef enum logic [1:0] {
        FC_NONE       = 2'd0,
        FC_MISMATCH   = 2'd1,
        FC_SKIPPED    = 2'd2,
        FC_HALT_EARLY = 2'd3
    } fail_code_e;

    // Table word layout: instruction count in the upper half, answer below.
    typedef struct packed {
        logic [CHK_DWIDTH-1:0] num;
        logic [CHK_DWIDTH-1:0] ans;
    } chk_entry_t;

endpackage

// File: rtl/chk_exp_table.sv
// Expected-result table: synchronous write, asynchronous read, so it maps
// onto distributed RAM. Contents are deliberately not reset.
module chk_exp_table #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = 5
) (
    input  logic                  CLK,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [2*DWIDTH-1:0]   wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [2*DWIDTH-1:0]   rdata
);

    logic [2*DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/riscv_result_checker.sv
// Self-check stage behind the RISC-V core: walks a table of expected
// (instruction count, output) pairs as the core retires and reports the verdict.
module riscv_result_checker
    import riscv_chk_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int DEPTH       = 32,
    parameter int IDX_W       = 5,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              EXP_WE,
    input  logic [IDX_W-1:0]  EXP_ADDR,
    input  logic [DWIDTH-1:0] EXP_NUM_INST,
    input  logic [DWIDTH-1:0] EXP_ANS,
    input  logic [IDX_W:0]    N_TESTS,
    input  logic              START,
    input  logic [DWIDTH-1:0] NUM_INST,
    input  logic [DWIDTH-1:0] OUTPUT_PORT,
    input  logic              HALT,
    output logic [2:0]        STATE,
    output logic              DONE,
    output logic [IDX_W:0]    PASS_CNT,
    output logic [IDX_W-1:0]  FAIL_IDX,
    output logic [DWIDTH-1:0] FAIL_VAL,
    output logic [1:0]        FAIL_CODE,
    output logic [DWIDTH-1:0] CYCLE_CNT
);

    localparam int CW = IDX_W + 1;
    localparam logic [DWIDTH-1:0] TO_LAST  = DWIDTH'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0]     DEPTH_CW = CW'(DEPTH);

    function automatic logic [DWIDTH-1:0] sat_inc(input logic [DWIDTH-1:0] v);
        return (&v) ? v : v + DWIDTH'(1);
    endfunction

    function automatic logic [CW-1:0] clamp_tests(input logic [CW-1:0] n);
        return (n > DEPTH_CW) ? DEPTH_CW : n;
    endfunction

    chk_state_e        state_q, state_d;
    fail_code_e        fail_code_q, fail_code_d;
    logic [CW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     n_tests_q, n_tests_d;
    logic [CW-1:0]     pass_cnt_q, pass_cnt_d;
    logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
    logic [DWIDTH-1:0] fail_val_q, fail_val_d;
    logic [DWIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [2*DWIDTH-1:0] rd_entry;
    logic [DWIDTH-1:0] e_num, e_ans;
    logic              tbl_we, checking, stop;

    // The table is frozen outside IDLE so a finished run cannot be disturbed.
    assign tbl_we = EXP_WE && (state_q == ST_IDLE);

    chk_exp_table #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_table (
        .CLK   (CLK),
        .we    (tbl_we),
        .waddr (EXP_ADDR),
        .wdata ({EXP_NUM_INST, EXP_ANS}),
        .raddr (ptr_q[IDX_W-1:0]),
        .rdata (rd_entry)
    );

    assign e_num = rd_entry[2*DWIDTH-1:DWIDTH];
    assign e_ans = rd_entry[DWIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        fail_code_d = fail_code_q;
        ptr_d       = ptr_q;
        n_tests_d   = n_tests_q;
        pass_cnt_d  = pass_cnt_q;
        fail_idx_d  = fail_idx_q;
        fail_val_d  = fail_val_q;
        cycle_cnt_d = cycle_cnt_q;
        checking    = (ptr_q < n_tests_q);
        stop        = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (checking && (NUM_INST == e_num)) begin
                    if (OUTPUT_PORT == e_ans) begin
                        ptr_d      = ptr_q + CW'(1);
                        pass_cnt_d = pass_cnt_q + CW'(1);
                    end else begin
                        stop        = 1'b1;
                        state_d     = ST_FAIL;
                        fail_code_d = FC_MISMATCH;
                        fail_idx_d  = ptr_q[IDX_W-1:0];
                        fail_val_d  = OUTPUT_PORT;
                    end
                end else if (checking && (NUM_INST > e_num)) begin
                    stop        = 1'b1;
                    state_d     = ST_FAIL;
                    fail_code_d = FC_SKIPPED;
                    fail_idx_d  = ptr_q[IDX_W-1:0];
                    fail_val_d  = OUTPUT_PORT;
                end

                // HALT judges the pointer after this cycle's match, so a halt
                // alongside the final entry still passes.
                if (!stop && HALT) begin
                    stop = 1'b1;
                    if (ptr_d == n_tests_q) begin
                        state_d = ST_PASS;
                    end else begin
                        state_d     = ST_FAIL;
                        fail_code_d = FC_HALT_EARLY;
                        fail_idx_d  = ptr_d[IDX_W-1:0];
                        fail_val_d  = OUTPUT_PORT;
                    end
                end else if (!stop && (cycle_cnt_q == TO_LAST)) begin
                    stop    = 1'b1;
                    state_d = ST_TIMEOUT;
                end

                if (!stop) begin
                    cycle_cnt_d = sat_inc(cycle_cnt_q);
                end
            end
            default: begin
                if (START) begin
                    state_d     = ST_RUN;
                    n_tests_d   = clamp_tests(N_TESTS);
                    ptr_d       = '0;
                    pass_cnt_d  = '0;
                    cycle_cnt_d = '0;
                    fail_code_d = FC_NONE;
                    fail_idx_d  = '0;
                    fail_val_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            fail_code_q <= FC_NONE;
            ptr_q       <= '0;
            n_tests_q   <= '0;
            pass_cnt_q  <= '0;
            fail_idx_q  <= '0;
            fail_val_q  <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fail_code_q <= fail_code_d;
            ptr_q       <= ptr_d;
            n_tests_q   <= n_tests_d;
            pass_cnt_q  <= pass_cnt_d;
            fail_idx_q  <= fail_idx_d;
            fail_val_q  <= fail_val_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign STATE     = state_q;
    assign DONE      = (state_q == ST_PASS) || (state_q == ST_FAIL) || (state_q == ST_TIMEOUT);
    assign PASS_CNT  = pass_cnt_q;
    assign FAIL_IDX  = fail_idx_q;
    assign FAIL_VAL  = fail_val_q;
    assign FAIL_CODE = fail_code_q;
    assign CYCLE_CNT = cycle_cnt_q;

endmodule

// File: tb/tb_riscv_result_checker.sv
// Bench for riscv_result_checker: directed scenarios plus randomized retire
// traces scored by a trace-level reference model.
module tb_riscv_result_checker;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int IW    = 5;
    localparam int TO    = 50;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          EXP_WE = 1'b0;
    logic [IW-1:0] EXP_ADDR = '0;
    logic [DW-1:0] EXP_NUM_INST = '0;
    logic [DW-1:0] EXP_ANS = '0;
    logic [IW:0]   N_TESTS = '0;
    logic          START = 1'b0;
    logic [DW-1:0] NUM_INST = '0;
    logic [DW-1:0] OUTPUT_PORT = '0;
    logic          HALT = 1'b0;
    logic [2:0]    STATE;
    logic          DONE;
    logic [IW:0]   PASS_CNT;
    logic [IW-1:0] FAIL_IDX;
    logic [DW-1:0] FAIL_VAL;
    logic [1:0]    FAIL_CODE;
    logic [DW-1:0] CYCLE_CNT;

    riscv_result_checker #(
        .DWIDTH(DW), .DEPTH(DEPTH), .IDX_W(IW), .TIMEOUT_CYC(TO)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .EXP_WE(EXP_WE), .EXP_ADDR(EXP_ADDR),
        .EXP_NUM_INST(EXP_NUM_INST), .EXP_ANS(EXP_ANS), .N_TESTS(N_TESTS),
        .START(START), .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT),
        .STATE(STATE), .DONE(DONE), .PASS_CNT(PASS_CNT), .FAIL_IDX(FAIL_IDX),
        .FAIL_VAL(FAIL_VAL), .FAIL_CODE(FAIL_CODE), .CYCLE_CNT(CYCLE_CNT)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int failed = 0;

    logic [DW-1:0] tnum [DEPTH];
    logic [DW-1:0] tans [DEPTH];
    logic [DW-1:0] q_num [$];
    logic [DW-1:0] q_out [$];
    bit            q_halt [$];

    int            e_st, e_pass, e_code, e_idx, e_cyc;
    logic [DW-1:0] e_val;

    function automatic void push(input logic [DW-1:0] n, input logic [DW-1:0] o, input bit h);
        q_num.push_back(n);
        q_out.push_back(o);
        q_halt.push_back(h);
    endfunction

    function automatic void clear_trace();
        q_num.delete();
        q_out.delete();
        q_halt.delete();
    endfunction

    // Idle filler guarantees every trace reaches a verdict (timeout at worst).
    function automatic void pad(input int len);
        while (q_num.size() < len) push('0, '0, 1'b0);
    endfunction

    function automatic void build_seq(input int last, input bit halt_on_last);
        clear_trace();
        for (int k = 0; k < last; k++) push(tnum[k], tans[k], halt_on_last && (k == last - 1));
        if (!halt_on_last) push(tnum[last-1], tans[last-1], 1'b1);
        pad(55);
    endfunction

    // Reference: walk the trace cycle by cycle against the list of expected
    // pairs, stopping at the first verdict.
    task automatic model(input int n_in);
        int n, ptr;
        n = (n_in > DEPTH) ? DEPTH : n_in;
        ptr = 0;
        e_st = 1; e_pass = 0; e_code = 0; e_idx = 0; e_val = '0; e_cyc = 0;
        for (int i = 0; i < q_num.size(); i++) begin
            if (ptr < n && q_num[i] == tnum[ptr]) begin
                if (q_out[i] == tans[ptr]) begin
                    ptr++;
                    e_pass++;
                end else begin
                    e_st = 3; e_code = 1; e_idx = ptr; e_val = q_out[i]; e_cyc = i;
                    return;
                end
            end else if (ptr < n && q_num[i] > tnum[ptr]) begin
                e_st = 3; e_code = 2; e_idx = ptr; e_val = q_out[i]; e_cyc = i;
                return;
            end
            if (q_halt[i]) begin
                e_cyc = i;
                if (ptr == n) e_st = 2;
                else begin
                    e_st = 3; e_code = 3; e_idx = ptr; e_val = q_out[i];
                end
                return;
            end
            if (i == TO - 1) begin
                e_st = 4; e_cyc = i;
                return;
            end
        end
    endtask

    task automatic write_entry(input int a, input logic [DW-1:0] n, input logic [DW-1:0] v);
        @(negedge CLK);
        EXP_WE = 1'b1; EXP_ADDR = IW'(a); EXP_NUM_INST = n; EXP_ANS = v;
        @(negedge CLK);
        EXP_WE = 1'b0;
    endtask

    task automatic drive_trace(input int n, input bit we, input int wa, input logic [DW-1:0] wn, input logic [DW-1:0] wv);
        @(negedge CLK);
        N_TESTS = (IW+1)'(n); START = 1'b1;
        EXP_WE = we; EXP_ADDR = IW'(wa); EXP_NUM_INST = wn; EXP_ANS = wv;
        @(negedge CLK);
        START = 1'b0; EXP_WE = 1'b0;
        for (int i = 0; i < q_num.size(); i++) begin
            NUM_INST = q_num[i]; OUTPUT_PORT = q_out[i]; HALT = q_halt[i];
            @(negedge CLK);
        end
        NUM_INST = '0; OUTPUT_PORT = '0; HALT = 1'b0;
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        tests++; if (STATE !== 3'd0) begin failed++; $display("FAIL reset_state: got %0d want 0", STATE); end
        tests++; if (DONE !== 1'b0) begin failed++; $display("FAIL reset_done: got %0b want 0", DONE); end
        tests++; if (PASS_CNT !== '0) begin failed++; $display("FAIL reset_pass_cnt: got %0d want 0", PASS_CNT); end
        tests++; if (FAIL_CODE !== 2'd0) begin failed++; $display("FAIL reset_fail_code: got %0d want 0", FAIL_CODE); end
        tests++; if (CYCLE_CNT !== '0) begin failed++; $display("FAIL reset_cycle_cnt: got %0d want 0", CYCLE_CNT); end
        tests++; if (FAIL_IDX !== '0 || FAIL_VAL !== '0) begin failed++; $display("FAIL reset_fail_fields: got idx %0d val %0h want 0 0", FAIL_IDX, FAIL_VAL); end
    endtask

    task automatic load_table();
        for (int k = 0; k < 23; k++) begin
            tnum[k] = DW'(k + 1);
            if (k == 2) tans[k] = 32'h5;
            else if (k == 21) tans[k] = 32'h1e;
            else if (k == 22) tans[k] = 32'h14;
            else if (k < 2) tans[k] = 32'h0;
            else tans[k] = DW'($urandom_range(0, 255));
            write_entry(k, tnum[k], tans[k]);
        end
    endtask

    task automatic test_full_pass(input string tag);
        build_seq(23, 1'b0);
        drive_trace(23, 1'b0, 0, '0, '0);
        tests++; if (STATE !== 3'd2) begin failed++; $display("FAIL %s_state: got %0d want 2", tag, STATE); end
        tests++; if (PASS_CNT !== 6'd23) begin failed++; $display("FAIL %s_pass_cnt: got %0d want 23", tag, PASS_CNT); end
        tests++; if (FAIL_CODE !== 2'd0) begin failed++; $display("FAIL %s_fail_code: got %0d want 0", tag, FAIL_CODE); end
        tests++; if (DONE !== 1'b1) begin failed++; $display("FAIL %s_done: got %0b want 1", tag, DONE); end
        tests++; if (CYCLE_CNT !== 32'd23) begin failed++; $display("FAIL %s_cycle_cnt: got %0d want 23", tag, CYCLE_CNT); end
    endtask

    task automatic test_mismatch();
        clear_trace();
        push(tnum[0], tans[0], 1'b0); push(tnum[1], tans[1], 1'b0); push(32'd3, 32'h6, 1'b0);
        pad(55);
        drive_trace(23, 1'b0, 0, '0, '0);
        tests++; if (STATE !== 3'd3) begin failed++; $display("FAIL mismatch_state: got %0d want 3", STATE); end
        tests++; if (FAIL_CODE !== 2'd1) begin failed++; $display("FAIL mismatch_code: got %0d want 1", FAIL_CODE); end
        tests++; if (FAIL_IDX !== 5'd2) begin failed++; $display("FAIL mismatch_idx: got %0d want 2", FAIL_IDX); end
        tests++; if (FAIL_VAL !== 32'h6) begin failed++; $display("FAIL mismatch_val: got %0h want 6", FAIL_VAL); end
        tests++; if (PASS_CNT !== 6'd2) begin failed++; $display("FAIL mismatch_pass_cnt: got %0d want 2", PASS_CNT); end
        tests++; if (CYCLE_CNT !== 32'd2) begin failed++; $display("FAIL mismatch_cycle_cnt: got %0d want 2", CYCLE_CNT); end
    endtask

    task automatic test_skip();
        clear_trace();
        push(tnum[0], tans[0], 1'b0); push(tnum[1], tans[1], 1'b0); push(32'd4, tans[3], 1'b0);
        pad(55);
        drive_trace(23, 1'b0, 0, '0, '0);
        tests++; if (STATE !== 3'd3) begin failed++; $display("FAIL skip_state: got %0d want 3", STATE); end
        tests++; if (FAIL_CODE !== 2'd2) begin failed++; $display("FAIL skip_code: got %0d want 2", FAIL_CODE); end
        tests++; if (FAIL_IDX !== 5'd2) begin failed++; $display("FAIL skip_idx: got %0d want 2", FAIL_IDX); end
        tests++; if (PASS_CNT !== 6'd2) begin failed++; $display("FAIL skip_pass_cnt: got %0d want 2", PASS_CNT); end
    endtask

    task automatic test_early_halt();
        build_seq(10, 1'b1);
        drive_trace(23, 1'b0, 0, '0, '0);
        tests++; if (STATE !== 3'd3) begin failed++; $display("FAIL early_halt_state: got %0d want 3", STATE); end
        tests++; if (FAIL_CODE !== 2'd3) begin failed++; $display("FAIL early_halt_code: got %0d want 3", FAIL_CODE); end
        tests++; if (PASS_CNT !== 6'd10) begin failed++; $display("FAIL early_halt_pass_cnt: got %0d want 10", PASS_CNT); end
    endtask

    task automatic test_halt_same_cycle();
        build_seq(23, 1'b1);
        drive_trace(23, 1'b0, 0, '0, '0);
        tests++; if (STATE !== 3'd2) begin failed++; $display("FAIL halt_same_state: got %0d want 2", STATE); end
        tests++; if (PASS_CNT !== 6'd23) begin failed++; $display("FAIL halt_same_pass_cnt: got %0d want 23", PASS_CNT); end
        tests++; if (CYCLE_CNT !== 32'd22) begin failed++; $display("FAIL halt_same_cycle_cnt: got %0d want 22", CYCLE_CNT); end
    endtask

    task automatic test_timeout();
        clear_trace();
        pad(60);
        drive_trace(23, 1'b0, 0, '0, '0);
        tests++; if (STATE !== 3'd4) begin failed++; $display("FAIL timeout_state: got %0d want 4", STATE); end
        tests++; if (CYCLE_CNT !== 32'd49) begin failed++; $display("FAIL timeout_cycle_cnt: got %0d want 49", CYCLE_CNT); end
        tests++; if (DONE !== 1'b1) begin failed++; $display("FAIL timeout_done: got %0b want 1", DONE); end
        tests++; if (FAIL_CODE !== 2'd0 || PASS_CNT !== '0) begin failed++; $display("FAIL timeout_fields: got code %0d pass %0d want 0 0", FAIL_CODE, PASS_CNT); end
    endtask

    task automatic test_zero_tests();
        clear_trace();
        for (int i = 0; i < 3; i++) push(DW'($urandom_range(1, 40)), $urandom, 1'b0);
        push(DW'($urandom_range(1, 40)), $urandom, 1'b1);
        pad(55);
        drive_trace(0, 1'b0, 0, '0, '0);
        tests++; if (STATE !== 3'd2) begin failed++; $display("FAIL zero_tests_state: got %0d want 2", STATE); end
        tests++; if (PASS_CNT !== '0) begin failed++; $display("FAIL zero_tests_pass_cnt: got %0d want 0", PASS_CNT); end
        tests++; if (CYCLE_CNT !== 32'd3) begin failed++; $display("FAIL zero_tests_cycle_cnt: got %0d want 3", CYCLE_CNT); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int n, r;
            n = $urandom_range(1, 23);
            clear_trace();
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(0, 99);
                if (r < 4) push(tnum[k], tans[k] ^ 32'h1, 1'b0);
                else if (r < 8) push(tnum[k] + 32'd1, tans[k], 1'b0);
                else push(tnum[k], tans[k], r < 11);
                if ($urandom_range(0, 3) == 0) push(tnum[k], $urandom, 1'b0);
            end
            push(tnum[n-1], tans[n-1], 1'b1);
            pad(55);
            model(n);
            drive_trace(n, 1'b0, 0, '0, '0);
            tests++; if (STATE !== 3'(e_st)) begin failed++; $display("FAIL rand%0d_state: got %0d want %0d", it, STATE, e_st); end
            tests++; if (PASS_CNT !== 6'(e_pass)) begin failed++; $display("FAIL rand%0d_pass_cnt: got %0d want %0d", it, PASS_CNT, e_pass); end
            tests++; if (FAIL_CODE !== 2'(e_code)) begin failed++; $display("FAIL rand%0d_code: got %0d want %0d", it, FAIL_CODE, e_code); end
            tests++; if (FAIL_IDX !== 5'(e_idx) || FAIL_VAL !== e_val) begin failed++; $display("FAIL rand%0d_fail_fields: got idx %0d val %0h want %0d %0h", it, FAIL_IDX, FAIL_VAL, e_idx, e_val); end
            tests++; if (CYCLE_CNT !== DW'(e_cyc)) begin failed++; $display("FAIL rand%0d_cycle_cnt: got %0d want %0d", it, CYCLE_CNT, e_cyc); end
            tests++; if (DONE !== (e_st >= 2)) begin failed++; $display("FAIL rand%0d_done: got %0b want %0b", it, DONE, e_st >= 2); end
        end
    endtask

    task automatic test_write_blocked();
        test_mismatch();
        write_entry(5, 32'd999, 32'hdead_beef);
        test_full_pass("rerun_after_blocked_write");
    endtask

    task automatic test_reset_mid_run();
        build_seq(23, 1'b0);
        @(negedge CLK);
        N_TESTS = 6'd23; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int i = 0; i < 5; i++) begin
            NUM_INST = q_num[i]; OUTPUT_PORT = q_out[i]; HALT = 1'b0;
            @(negedge CLK);
        end
        RSTn = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1; NUM_INST = '0; OUTPUT_PORT = '0;
        tests++; if (STATE !== 3'd0) begin failed++; $display("FAIL midrun_reset_state: got %0d want 0", STATE); end
        tests++; if (PASS_CNT !== '0 || CYCLE_CNT !== '0) begin failed++; $display("FAIL midrun_reset_counts: got pass %0d cyc %0d want 0 0", PASS_CNT, CYCLE_CNT); end
        tests++; if (DONE !== 1'b0 || FAIL_CODE !== 2'd0 || FAIL_IDX !== '0 || FAIL_VAL !== '0) begin failed++; $display("FAIL midrun_reset_fields: got done %0b code %0d idx %0d val %0h want 0", DONE, FAIL_CODE, FAIL_IDX, FAIL_VAL); end
    endtask

    task automatic test_clamp_write_start();
        for (int k = 23; k < DEPTH; k++) begin
            tnum[k] = DW'(k + 1);
            tans[k] = $urandom;
            if (k < DEPTH - 1) write_entry(k, tnum[k], tans[k]);
        end
        build_seq(DEPTH, 1'b0);
        model(63);
        drive_trace(63, 1'b1, DEPTH - 1, tnum[DEPTH-1], tans[DEPTH-1]);
        tests++; if (STATE !== 3'd2) begin failed++; $display("FAIL clamp_state: got %0d want 2", STATE); end
        tests++; if (PASS_CNT !== 6'd32) begin failed++; $display("FAIL clamp_pass_cnt: got %0d want 32", PASS_CNT); end
        tests++; if (CYCLE_CNT !== DW'(e_cyc)) begin failed++; $display("FAIL clamp_cycle_cnt: got %0d want %0d", CYCLE_CNT, e_cyc); end
    endtask

    initial begin
        test_reset();
        load_table();
        test_full_pass("full_pass");
        test_mismatch();
        test_skip();
        test_early_halt();
        test_halt_same_cycle();
        test_timeout();
        test_zero_tests();
        test_random();
        test_write_blocked();
        test_reset_mid_run();
        test_clamp_write_start();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
